// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: small FIFO of {pc, instr} pairs
// with first-word fall-through head and single-cycle flush on redirect.
module if_id_queue #(
    parameter int unsigned          XLEN      = 32,
    parameter int unsigned          DEPTH     = 4,
    parameter logic [XLEN-1:0]      NOP_INSTR = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [2*XLEN-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              push, pop;
    logic [2*XLEN-1:0] head;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    assign head      = mem_q[rd_ptr_q];
    assign out_pc    = out_valid ? head[2*XLEN-1:XLEN] : '0;
    assign out_instr = out_valid ? head[XLEN-1:0] : NOP_INSTR;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= {in_pc, in_instr};
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: stimulus pushes expected pairs,
// a negedge monitor checks head, count and handshake flags.
module tb_if_id_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_pc = '0;
    logic [31:0]     in_instr = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [31:0]     out_pc;
    logic [31:0]     out_instr;
    logic [2:0]      count;

    logic [63:0]     sbq[$];
    int              n_cmp = 0;
    int              n_bad = 0;

    always #5 clk = ~clk;

    if_id_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares the DUT against the scoreboard each negedge and
    // retires the head when decode takes it at the coming edge.
    always @(negedge clk) begin
        chk("count", 64'(count), 64'(sbq.size()));
        chk("out_valid", 64'(out_valid), 64'(sbq.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(sbq.size() != DEPTH));
        if (sbq.size() != 0) begin
            chk("out_pc", 64'(out_pc), 64'(sbq[0][63:32]));
            chk("out_instr", 64'(out_instr), 64'(sbq[0][31:0]));
            if (out_ready) void'(sbq.pop_front());
        end else begin
            chk("empty_pc", 64'(out_pc), 64'h0);
            chk("empty_instr", 64'(out_instr), 64'(NOP));
        end
    end

    task automatic step(input logic iv, input logic [31:0] pc,
                        input logic [31:0] ins, input logic ordy,
                        input logic fl);
        logic full;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        full      = (sbq.size() == DEPTH);
        @(posedge clk);
        if (fl) sbq.delete();
        else if (iv && !full) sbq.push_back({pc, ins});
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    logic [31:0] fill_pc [5];
    logic [31:0] fill_in [5];

    initial begin
        fill_pc = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10};
        fill_in = '{32'h00100093, 32'h00200113, 32'h00300193,
                    32'h00400213, 32'h00500293};

        // Reset held two cycles; monitor checks reset outputs.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_ready", 64'(in_ready), 64'h1);
        chk("rst_instr", 64'(out_instr), 64'(NOP));
        chk("rst_pc", 64'(out_pc), 64'h0);

        // Fill with decode stalled; fifth push must be dropped.
        for (int i = 0; i < 5; i++)
            step(1'b1, fill_pc[i], fill_in[i], 1'b0, 1'b0);
        chk("full_count", 64'(count), 64'd4);
        chk("full_ready", 64'(in_ready), 64'h0);
        chk("hold_pc", 64'(out_pc), 64'h00);
        chk("hold_instr", 64'(out_instr), 64'h00100093);
        idle();

        // Drain in order.
        for (int i = 0; i < 4; i++)
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("drain_valid", 64'(out_valid), 64'h0);
        chk("drain_count", 64'(count), 64'h0);

        // Streaming with pointer wrap.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h100 + 32'(4 * i), 32'h00000093 | 32'(i << 20),
                 1'b1, 1'b0);
            chk("stream_count", 64'(count), 64'd1);
            chk("stream_pc", 64'(out_pc), 64'(32'h100 + 32'(4 * i)));
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("stream_end", 64'(count), 64'h0);

        // Flush beats simultaneous push and pop.
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h300 + 32'(4 * i), 32'h00A00513 + 32'(i),
                 1'b0, 1'b0);
        chk("pre_flush", 64'(count), 64'd3);
        step(1'b1, 32'h200, 32'h00B00593, 1'b1, 1'b1);
        chk("flush_count", 64'(count), 64'h0);
        chk("flush_valid", 64'(out_valid), 64'h0);
        chk("flush_ready", 64'(in_ready), 64'h1);
        step(1'b1, 32'h200, 32'h00B00593, 1'b0, 1'b0);
        chk("post_count", 64'(count), 64'd1);
        chk("post_pc", 64'(out_pc), 64'h200);
        chk("post_instr", 64'(out_instr), 64'h00B00593);

        // Async reset between edges with two entries queued.
        step(1'b1, 32'h204, 32'h00C00613, 1'b0, 1'b0);
        idle();
        chk("pre_rst", 64'(count), 64'd2);
        #2;
        rst = 1'b1;
        sbq.delete();
        #1;
        chk("arst_valid", 64'(out_valid), 64'h0);
        chk("arst_count", 64'(count), 64'h0);
        chk("arst_ready", 64'(in_ready), 64'h1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Queue works normally after reset.
        step(1'b1, 32'h400, 32'h00D00693, 1'b0, 1'b0);
        chk("after_pc", 64'(out_pc), 64'h400);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();
        chk("final_sb", 64'(sbq.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction fetch queue between the fetch unit and the decode stage.
- Captures each fetched {pc, instruction} pair into a small FIFO and presents the oldest entry to decode with a valid/ready handshake.
- Decouples fetch from decode stalls; a single-cycle flush empties it on redirect.
- Decode-side outputs come from storage (first-word fall-through); there is no combinational path from in_* to out_*.

Parameters:
- XLEN, 32, width of pc and instruction.
- DEPTH, 4, number of entries; power of two, minimum 2.
- NOP_INSTR, 32'h00000013, instruction presented when empty (addi x0,x0,0).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous queue clear (pipeline redirect).
- in_valid  input  1  fetch presents a valid pair.
- in_ready  output  1  queue can accept a pair this cycle.
- in_pc  input  XLEN  pc of the fetched instruction.
- in_instr  input  XLEN  fetched instruction word.
- out_valid  output  1  head entry valid for decode.
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  XLEN  pc of the head entry.
- out_instr  output  XLEN  instruction of the head entry.
- count  output  log2(DEPTH)+1  current number of occupied entries.

Behaviour:
- State: storage array DEPTH x (2*XLEN), wr_ptr and rd_ptr each log2(DEPTH) bits wrapping modulo DEPTH, and count.
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0. Storage contents are don't-care.
- Outputs during reset: out_valid=0, in_ready=1, out_pc=0, out_instr=NOP_INSTR.
- Handshake:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = (count != DEPTH), independent of out_ready; there is no bypass when full.
  - out_valid = (count != 0).
- Push at a clock edge: store {in_pc, in_instr} at wr_ptr, then wr_ptr+1.
- Pop at a clock edge: rd_ptr+1.
- Count update: push only +1; pop only -1; push and pop together leaves count unchanged. Simultaneous push/pop is legal at any non-full count, including count=1.
- Head outputs: out_pc and out_instr = mem[rd_ptr] when count!=0. When empty, out_pc=0 and out_instr=NOP_INSTR.
- Latency: a pair pushed at edge N is visible on out_* after edge N, with out_valid=1 in the cycle following the push (1-cycle latency, empty case).
- Holding: with out_ready=0, out_* must remain stable while out_valid=1.
- Flush:
  - At the edge where flush=1, wr_ptr=rd_ptr=0 and count=0.
  - Any push or pop in that cycle is discarded.
  - Next cycle: out_valid=0 and in_ready=1.
  - Flush has priority over push and pop.
- Full (count==DEPTH): in_ready=0 and in_valid is ignored. A pop in that cycle frees one slot for the next cycle.
- Empty (count==0): out_ready is ignored and no pointer movement occurs.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no gaps, so FIFO order is preserved across wrap.
- Reset mid-operation: asynchronous return to the reset state regardless of pending handshakes.

Test Plan:
- Reset check: assert rst for 2 cycles, then release -> out_valid=0, in_ready=1, count=0, out_instr=32'h00000013, out_pc=0.
- Fill and stall: push pc=0x00,0x04,0x08,0x0C (instr 0x00100093, 0x00200113, 0x00300193, 0x00400213) with out_ready=0 -> count=4, in_ready=0. A 5th push (pc 0x10) is ignored, and out_pc=0x00 and out_instr=0x00100093 stay stable.
- Drain in order: from full, set out_ready=1 for 4 cycles -> out_pc sequence 0x00, 0x04, 0x08, 0x0C, then out_valid=0 and count=0.
- Streaming: simultaneous push/pop every cycle over 10 instructions starting at pc 0x100 -> count stays 1, pointers wrap past DEPTH-1, and out_pc increments by 4 each cycle with no loss or duplicates.
- Flush priority: with count=3, assert flush together with in_valid=1 (pc 0x200) and out_ready=1 -> next cycle count=0, out_valid=0. A subsequent push of pc 0x200 appears as head with count=1.
- Async reset mid-stream: with count=2, raise rst between clock edges -> out_valid=0 and count=0 immediately, before the next edge.
